// File: rtl/conversor_bcd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | conversor_bcd_pkg                                                    |
// | Shared state encodings and default sizes for the BCD converter.      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package conversor_bcd_pkg;

  localparam int c_WIDTH_DEF  = 12;
  localparam int c_DIGITS_DEF = 4;

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_SHIFT = 2'd1;
  localparam logic [1:0] c_ST_DONE  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/conversor_bcd_ajuste_add3.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ajuste_add3                                                          |
// | Double-dabble digit correction: adds 3 when the digit is 5 or more.  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module ajuste_add3 (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule
`default_nettype wire

// File: rtl/conversor_bcd.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | conversor_bcd                                                        |
// | Sequential signed-binary to sign + packed-BCD converter.             |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module conversor_bcd
  import conversor_bcd_pkg::*;
#(
  parameter int WIDTH  = c_WIDTH_DEF,
  parameter int DIGITS = c_DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      F,
  output logic                  busy,
  output logic                  done,
  output logic                  sign,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int              c_CW   = $clog2(WIDTH + 1);
  localparam int              c_BW   = 4 * DIGITS;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);
  localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

  logic [1:0]          r_state;
  logic [WIDTH-1:0]    r_mag;
  logic [c_BW-1:0]     r_work;
  logic [c_BW-1:0]     r_bcd;
  logic [c_CW-1:0]     r_cnt;
  logic                r_sign_cap;
  logic                r_sign;

  logic [c_BW-1:0]       w_adj;
  logic [WIDTH-1:0]      w_abs;
  logic [c_BW+WIDTH-1:0] w_cat;
  logic [c_BW+WIDTH-1:0] w_shift;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      ajuste_add3 u_add3 (
        .i_digit (r_work[4*gi +: 4]),
        .o_digit (w_adj[4*gi +: 4])
      );
    end
  endgenerate

  // Two's-complement negate; the most negative value maps onto itself,
  // which read as unsigned is exactly its magnitude.
  assign w_abs   = F[WIDTH-1] ? ((~F) + {{(WIDTH-1){1'b0}}, 1'b1}) : F;
  assign w_cat   = {w_adj, r_mag};
  assign w_shift = w_cat << 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= c_ST_IDLE;
      r_mag      <= '0;
      r_work     <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_sign_cap <= 1'b0;
      r_sign     <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (start) begin
            r_sign_cap <= F[WIDTH-1];
            r_mag      <= w_abs;
            r_work     <= '0;
            r_cnt      <= '0;
            r_state    <= c_ST_SHIFT;
          end
        end
        c_ST_SHIFT: begin
          {r_work, r_mag} <= w_shift;
          r_cnt           <= r_cnt + c_ONE;
          if (r_cnt == c_LAST) begin
            r_bcd   <= w_shift[c_BW+WIDTH-1 -: c_BW];
            r_sign  <= r_sign_cap;
            r_state <= c_ST_DONE;
          end
        end
        c_ST_DONE: r_state <= c_ST_IDLE;
        default:   r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign busy = (r_state == c_ST_SHIFT);
  assign done = (r_state == c_ST_DONE);
  assign sign = r_sign;
  assign bcd  = r_bcd;

endmodule
`default_nettype wire

// File: tb/tb_conversor_bcd.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_conversor_bcd                                                     |
// | Self-checking bench: vector table, corner sequences, full sweep.     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_conversor_bcd;

  localparam int WIDTH  = 12;
  localparam int DIGITS = 4;

  logic        clk;
  logic        rst;
  logic        start;
  logic [11:0] F;
  logic        busy;
  logic        done;
  logic        sign;
  logic [15:0] bcd;

  int errors;
  int checks;
  int n_done;
  logic [16:0] q[$];
  logic [16:0] prev;

  typedef struct {
    logic [11:0] f;
    logic        s;
    logic [15:0] b;
  } vec_t;

  conversor_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .F     (F),
    .busy  (busy),
    .done  (done),
    .sign  (sign),
    .bcd   (bcd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Independent reference: arithmetic magnitude, digits by division.
  function automatic logic [16:0] ref_model(input logic [11:0] f);
    int m;
    logic [15:0] b;
    m = f[11] ? (4096 - int'(f)) : int'(f);
    b = {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
    return {f[11], b};
  endfunction

  // Scoreboard consumer: every done pulse pops one expected result.
  always @(posedge clk) begin
    logic [16:0] e;
    #1;
    if (done) begin
      n_done++;
      if (q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = q.pop_front();
        chk("sign", 32'(sign), 32'(e[16]));
        chk("bcd", 32'(bcd), 32'(e[15:0]));
      end
    end
  end

  task automatic conv(input logic [11:0] f, input logic [16:0] exp, input bit tm);
    int  n;
    bit  seen;
    @(negedge clk);
    F     = f;
    start = 1'b1;
    q.push_back(exp);
    @(posedge clk);
    #1;
    start = 1'b0;
    F     = ~f;
    n     = 0;
    seen  = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (tm && n == 1) chk("busy_in_shift", 32'(busy), 32'd1);
      if (tm && n == 6) chk("bcd_held", 32'(bcd), 32'(prev[15:0]));
      if (done) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 32'(seen), 32'd1);
    else if (tm) chk("latency", 32'(n), 32'(WIDTH));
    prev = exp;
    @(posedge clk);
    #1;
    if (tm) begin
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("busy_idle", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    vec_t vt[8];
    int   d0;

    errors = 0;
    checks = 0;
    n_done = 0;
    prev   = '0;
    rst    = 1'b1;
    start  = 1'b0;
    F      = '0;

    vt[0] = '{12'd155, 1'b0, 16'h0155};
    vt[1] = '{12'hF60, 1'b1, 16'h0160};
    vt[2] = '{12'h800, 1'b1, 16'h2048};
    vt[3] = '{12'h7FF, 1'b0, 16'h2047};
    vt[4] = '{12'h000, 1'b0, 16'h0000};
    vt[5] = '{12'hFFF, 1'b1, 16'h0001};
    vt[6] = '{12'h001, 1'b0, 16'h0001};
    vt[7] = '{12'h999, 1'b1, 16'h1639};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sign", 32'(sign), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("idle_no_start_busy", 32'(busy), 32'd0);

    foreach (vt[i]) conv(vt[i].f, {vt[i].s, vt[i].b}, 1'b1);

    // start held high with F changing every cycle: captures every WIDTH+2 edges.
    d0 = n_done;
    for (int k = 0; k < 3 * (WIDTH + 2); k++) begin
      @(negedge clk);
      F     = 12'($urandom);
      start = 1'b1;
      if (k % (WIDTH + 2) == 0) q.push_back(ref_model(F));
    end
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("held_start_done_count", 32'(n_done - d0), 32'd3);
    prev = '0;

    // Abort mid-conversion with an asynchronous reset.
    conv(12'd155, 17'h00155, 1'b0);
    @(negedge clk);
    F     = 12'h123;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sign", 32'(sign), 32'd0);
    chk("abort_bcd", 32'(bcd), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    d0  = n_done;
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(n_done - d0), 32'd0);
    prev = '0;
    conv(12'd0, 17'h00000, 1'b1);

    for (int v = 0; v < 4096; v++) conv(12'(v), ref_model(12'(v)), 1'b0);

    repeat (2) @(posedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
